inst_fetch: RTL and testbench

- Front end of the core: produces the 32-bit instruction words consumed by the instruction decoder.
- Reads byte-wide instruction memory, one byte per cycle, and assembles each little-endian word.
- Holds the word with its PC in a one-entry output register under a valid/ready handshake.
- Restarts at a new PC on a jump/branch redirect.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch.sv | 143 ++++++++++++++
 tb/tb_inst_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   fetch_state_e     : FETCH while bytes are being gathered, HOLD while a
//                       complete word waits for the decoder.
//   DEFAULT_ADDR_W    : default PC / memory address width.
//   DEFAULT_RESET_PC  : default PC loaded on reset.
package inst_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam int unsigned DEFAULT_ADDR_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Number of byte reads needed to build one instruction word.
  localparam logic [2:0] BYTES_PER_WORD = 3'd4;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch front end.
// Reads a byte-wide instruction memory one byte per cycle, assembles each
// little-endian 32-bit word and presents it to the decoder through a
// one-entry valid/ready output register. A jump/branch redirect restarts
// the fetch at an arbitrary (unaligned) PC.
//
// Ports:
//   clk_in      : clock, all state on the rising edge
//   rst_n_in    : asynchronous active-low reset
//   rdy_in      : global ready; 0 freezes every register and blocks requests
//   mem_gnt     : arbiter grant for this cycle's read request
//   mem_din     : read data, valid the rdy cycle after a granted request
//   mem_rd_en   : byte read request
//   mem_a       : byte address of the request (0 when no request)
//   jump_en     : redirect strobe
//   jump_pc     : redirect target
//   inst_ready  : decoder accepts inst this cycle
//   inst_valid  : inst / inst_pc hold a complete word
//   inst        : assembled instruction word
//   inst_pc     : address of inst
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_a,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        issue_idx_q;
  logic [1:0]        recv_idx_q;
  logic              rd_pending_q;
  logic              inst_valid_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [7:0]        byte_q [4];

  logic reqGranted;
  logic lastByte;

  assign reqGranted = mem_rd_en && mem_gnt;
  // The fourth byte completes the word; it is taken straight from mem_din.
  assign lastByte   = (state_q == FETCH) && rd_pending_q && (recv_idx_q == 2'd3);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= FETCH;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect overrides everything, including a handshake.
  always_comb begin
    state_d = state_q;
    if (jump_en) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:   if (lastByte) state_d = HOLD;
        HOLD:    if (inst_ready) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // Request outputs. Reset is folded in so the bus is quiet while held in reset.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_a     = '0;
    if (rst_n_in && rdy_in && !jump_en && (state_q == FETCH) &&
        (issue_idx_q < BYTES_PER_WORD)) begin
      mem_rd_en = 1'b1;
      mem_a     = pc_q + ADDR_W'(issue_idx_q);
    end
  end

  // Datapath: issue/receive counters, byte assembly and the output register.
  // A request that is not granted leaves issue_idx untouched, so the same
  // address is re-presented; rd_pending tracks whether a byte returns next.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q         <= RESET_PC;
      issue_idx_q  <= '0;
      recv_idx_q   <= '0;
      rd_pending_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      for (int i = 0; i < 4; i++) byte_q[i] <= '0;
    end else if (rdy_in) begin
      if (jump_en) begin
        pc_q         <= jump_pc;
        issue_idx_q  <= '0;
        recv_idx_q   <= '0;
        rd_pending_q <= 1'b0;
        inst_valid_q <= 1'b0;
      end else if (state_q == FETCH) begin
        rd_pending_q <= reqGranted;
        if (reqGranted) begin
          issue_idx_q <= issue_idx_q + 3'd1;
        end
        if (rd_pending_q) begin
          byte_q[recv_idx_q] <= mem_din;
          recv_idx_q         <= recv_idx_q + 2'd1;
        end
        if (lastByte) begin
          inst_q       <= {mem_din, byte_q[2], byte_q[1], byte_q[0]};
          inst_pc_q    <= pc_q;
          inst_valid_q <= 1'b1;
        end
      end else begin
        rd_pending_q <= 1'b0;
        if (inst_ready) begin
          inst_valid_q <= 1'b0;
          pc_q         <= pc_q + ADDR_W'(4);
          issue_idx_q  <= '0;
          recv_idx_q   <= '0;
        end
      end
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a small byte-memory model whose
// read data appears the rdy cycle after a granted request.
module tb_inst_fetch;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        mem_rd_en;
  logic [31:0] mem_a;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int compareCount = 0;
  int failCount    = 0;

  inst_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .mem_gnt    (mem_gnt),
    .mem_din    (mem_din),
    .mem_rd_en  (mem_rd_en),
    .mem_a      (mem_a),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory contents used by the directed tests; everything else reads EE.
  function automatic logic [7:0] memByte(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h50;
      32'h0000_0003: return 8'h00;
      32'h0000_0004: return 8'h93;
      32'h0000_0005: return 8'h00;
      32'h0000_0006: return 8'h10;
      32'h0000_0007: return 8'h00;
      32'h0000_0008: return 8'h13;
      32'h0000_0009: return 8'h01;
      32'h0000_000A: return 8'h20;
      32'h0000_000B: return 8'h00;
      32'h0000_1002: return 8'hAA;
      32'h0000_1003: return 8'hBB;
      32'h0000_1004: return 8'hCC;
      32'h0000_1005: return 8'hDD;
      32'h0000_2000: return 8'h01;
      32'h0000_2001: return 8'h02;
      32'h0000_2002: return 8'h03;
      32'h0000_2003: return 8'h04;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      default:       return 8'hEE;
    endcase
  endfunction

  // Registered memory read that freezes with rdy_in.
  initial mem_din = 8'h00;
  always @(posedge clk_in) begin
    if (rdy_in && mem_rd_en && mem_gnt) mem_din <= memByte(mem_a);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs shortly after a falling edge, then settle.
  task automatic applyStimulus(input logic rdy, input logic gnt, input logic jen,
                               input logic [31:0] jpc, input logic ready);
    rdy_in     = rdy;
    mem_gnt    = gnt;
    jump_en    = jen;
    jump_pc    = jpc;
    inst_ready = ready;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk_in);
  endtask

  // n granted request cycles at consecutive addresses starting from base.
  task automatic fetchBytes(input string tag, input logic [31:0] base, input int n);
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = base + 32'(i);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("%s_rden%0d", tag, i), {31'b0, mem_rd_en}, 32'd1);
      checkOutput($sformatf("%s_addr%0d", tag, i), mem_a, addr);
      nextCycle();
    end
  endtask

  // Return cycle of the last byte (no request, not yet valid), then the
  // first valid cycle with the given decoder/redirect inputs.
  task automatic waitWord(input string tag, input logic [31:0] expInst,
                          input logic [31:0] expPc, input logic jen,
                          input logic [31:0] jpc, input logic ready);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput({tag, "_retRden"}, {31'b0, mem_rd_en}, 32'd0);
    checkOutput({tag, "_retValid"}, {31'b0, inst_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, jen, jpc, ready);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    checkOutput({tag, "_inst"}, inst, expInst);
    checkOutput({tag, "_pc"}, inst_pc, expPc);
    checkOutput({tag, "_holdRden"}, {31'b0, mem_rd_en}, 32'd0);
    nextCycle();
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in = 1'b1; mem_gnt = 1'b1; jump_en = 1'b0; jump_pc = '0; inst_ready = 1'b1;
    #2;
    // Reset state, with rdy high so a missing reset gate would show.
    checkOutput("rst_rden", {31'b0, mem_rd_en}, 32'd0);
    checkOutput("rst_addr", mem_a, 32'd0);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_pc", inst_pc, 32'd0);
    nextCycle();
    nextCycle();
    rst_n_in = 1'b1;

    // Basic word at 0, accepted immediately.
    fetchBytes("w0", 32'h0, 4);
    waitWord("w0", 32'h0050_0513, 32'h0, 1'b0, 32'h0, 1'b1);

    // Word at 4 held for 10 cycles before acceptance.
    fetchBytes("w1", 32'h4, 4);
    waitWord("w1", 32'h0010_0093, 32'h4, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, (i == 9));
      checkOutput($sformatf("w1_stallValid%0d", i), {31'b0, inst_valid}, 32'd1);
      checkOutput($sformatf("w1_stallInst%0d", i), inst, 32'h0010_0093);
      checkOutput($sformatf("w1_stallPc%0d", i), inst_pc, 32'h4);
      checkOutput($sformatf("w1_stallRden%0d", i), {31'b0, mem_rd_en}, 32'd0);
      nextCycle();
    end

    // Word at 8 with the grant withheld on address A.
    fetchBytes("w2", 32'h8, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("w2_nogntAddr", mem_a, 32'hA);
    nextCycle();
    fetchBytes("w2r", 32'hA, 2);
    waitWord("w2", 32'h0020_0113, 32'h8, 1'b0, 32'h0, 1'b1);

    // Redirect after two bytes of the word at C.
    fetchBytes("w3pre", 32'hC, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1002, 1'b0);
    checkOutput("w3_jumpRden", {31'b0, mem_rd_en}, 32'd0);
    nextCycle();
    fetchBytes("w3", 32'h0000_1002, 4);
    // Redirect in the same cycle the decoder accepts the held word.
    waitWord("w3", 32'hDDCC_BBAA, 32'h0000_1002, 1'b1, 32'h0000_2000, 1'b1);
    checkOutput("w4_droppedValid", {31'b0, inst_valid}, 32'd0);
    fetchBytes("w4", 32'h0000_2000, 4);
    waitWord("w4", 32'h0403_0201, 32'h0000_2000, 1'b0, 32'h0, 1'b1);

    // Wrapping fetch at FFFFFFFE with a 3-cycle rdy stall after a grant.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    checkOutput("w5_jumpRden", {31'b0, mem_rd_en}, 32'd0);
    nextCycle();
    fetchBytes("w5a", 32'hFFFF_FFFE, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("w5_stallRden%0d", i), {31'b0, mem_rd_en}, 32'd0);
      nextCycle();
    end
    fetchBytes("w5b", 32'h0, 2);
    waitWord("w5", 32'h0513_2211, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1);

    // Reset in the middle of the next word (at 2), then restart at 0.
    fetchBytes("w6", 32'h2, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    rst_n_in = 1'b0;
    #1;
    checkOutput("midrst_rden", {31'b0, mem_rd_en}, 32'd0);
    checkOutput("midrst_addr", mem_a, 32'd0);
    nextCycle();
    rst_n_in = 1'b1;
    fetchBytes("w7", 32'h0, 4);
    waitWord("w7", 32'h0050_0513, 32'h0, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
